// File: rtl/scan_decoder.sv
// Registered SEL_W-to-2**SEL_W one-hot select decoder with direct and prescaled auto-scan modes.
// Define SCAN_DIR_EN to add the `dir` input (0 = scan up, 1 = scan down).
module scan_decoder #(
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned DIV        = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  load,
`ifdef SCAN_DIR_EN
  input  logic                  dir,
`endif
  output logic [2**SEL_W-1:0]   out,
  output logic [SEL_W-1:0]      idx,
  output logic                  tick
);

  localparam int unsigned NOUT  = 2**SEL_W;
  localparam int unsigned PW    = $clog2(DIV) + 1;
  localparam logic [PW-1:0] PTERM = PW'(DIV - 1);
  localparam logic [NOUT-1:0] INACTIVE = {NOUT{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [PW-1:0]     presc_cur;
  logic              tick_q, tick_d;
  logic [NOUT-1:0]   out_q, out_d;
  logic [SEL_W-1:0]  idx_step;

  function automatic logic [NOUT-1:0] decode(input logic [SEL_W-1:0] s);
    logic [NOUT-1:0] oh;
    oh = NOUT'(1) << s;
    return oh ^ {NOUT{ACTIVE_LOW}};
  endfunction

  // Scan step direction.
  always_comb begin
`ifdef SCAN_DIR_EN
    idx_step = dir ? (idx_q - SEL_W'(1)) : (idx_q + SEL_W'(1));
`else
    idx_step = idx_q + SEL_W'(1);
`endif
  end

  // Next state and datapath; the prescaler restarts from 0 whenever scan is freshly entered.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    presc_d   = presc_q;
    presc_cur = '0;
    tick_d    = 1'b0;
    out_d     = INACTIVE;

    if (!en) begin
      state_d = ST_IDLE;
    end else if (!mode) begin
      state_d = ST_DIRECT;
    end else begin
      state_d = ST_SCAN;
    end

    case (state_d)
      ST_IDLE: begin
        out_d = INACTIVE;
      end
      ST_DIRECT: begin
        idx_d   = sel;
        presc_d = '0;
        out_d   = decode(sel);
      end
      ST_SCAN: begin
        presc_cur = (state_q == ST_SCAN) ? presc_q : '0;
        if (load) begin
          idx_d   = sel;
          presc_d = '0;
        end else if (presc_cur == PTERM) begin
          presc_d = '0;
          idx_d   = idx_step;
          tick_d  = 1'b1;
        end else begin
          presc_d = presc_cur + PW'(1);
        end
        out_d = decode(idx_d);
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      presc_q <= '0;
      tick_q  <= 1'b0;
      out_q   <= INACTIVE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      out_q   <= out_d;
    end
  end

  assign out  = out_q;
  assign idx  = idx_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder: two instances (4-line DIV=4 active-high, 8-line DIV=1 active-low)
// driven by directed and random stimulus, checked against a clock-counting reference model.
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       rst, en, mode, load;
  logic [1:0] sel0;
  logic [2:0] sel1;
  logic [3:0] out0;
  logic [1:0] idx0;
  logic       tick0;
  logic [7:0] out1;
  logic [2:0] idx1;
  logic       tick1;
`ifdef SCAN_DIR_EN
  logic       dir;
`endif

  always #5 clk = ~clk;

  scan_decoder #(.SEL_W(2), .DIV(4), .ACTIVE_LOW(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel0), .load(load),
`ifdef SCAN_DIR_EN
    .dir(dir),
`endif
    .out(out0), .idx(idx0), .tick(tick0)
  );

  scan_decoder #(.SEL_W(3), .DIV(1), .ACTIVE_LOW(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel1), .load(load),
`ifdef SCAN_DIR_EN
    .dir(dir),
`endif
    .out(out1), .idx(idx1), .tick(tick1)
  );

  typedef struct {
    logic [7:0] out;
    logic [2:0] idx;
    logic       tick;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: active index, clocks elapsed since the last scan restart/step.
  int          m_idx[2];
  int          m_cnt[2];
  bit          m_scan[2];
  int unsigned p_nout[2] = '{4, 8};
  int unsigned p_div[2]  = '{4, 1};
  bit          p_al[2]   = '{1'b0, 1'b1};

  function automatic exp_t model(int d, bit r, bit e, bit m, bit ld, bit dr, int s);
    exp_t x;
    bit   active;
    int   oh;
    x.tick = 1'b0;
    active = 1'b0;
    if (r) begin
      m_idx[d] = 0; m_cnt[d] = 0; m_scan[d] = 1'b0;
    end else if (!e) begin
      m_scan[d] = 1'b0;
    end else if (!m) begin
      m_idx[d] = s; m_scan[d] = 1'b0; active = 1'b1;
    end else begin
      if (!m_scan[d]) m_cnt[d] = 0;
      m_scan[d] = 1'b1;
      active = 1'b1;
      if (ld) begin
        m_idx[d] = s; m_cnt[d] = 0;
      end else begin
        m_cnt[d] = m_cnt[d] + 1;
        if (m_cnt[d] == int'(p_div[d])) begin
          m_cnt[d] = 0;
          if (dr) m_idx[d] = (m_idx[d] + int'(p_nout[d]) - 1) % int'(p_nout[d]);
          else    m_idx[d] = (m_idx[d] + 1) % int'(p_nout[d]);
          x.tick = 1'b1;
        end
      end
    end
    oh = active ? (1 << m_idx[d]) : 0;
    if (p_al[d]) oh = ~oh & ((1 << p_nout[d]) - 1);
    x.out = 8'(oh);
    x.idx = 3'(m_idx[d]);
    return x;
  endfunction

  task automatic drive(bit r, bit e, bit m, bit ld, bit dr, int s0, int s1);
    exp_t e0, e1;
    bit   dre;
    dre  = 1'b0;
    rst  = r;
    en   = e;
    mode = m;
    load = ld;
    sel0 = 2'(s0);
    sel1 = 3'(s1);
`ifdef SCAN_DIR_EN
    dre = dr;
    dir = dr;
`endif
    e0 = model(0, r, e, m, ld, dre, s0 & 3);
    e1 = model(1, r, e, m, ld, dre, s1 & 7);
    @(posedge clk);
    q0.push_back(e0);
    q1.push_back(e1);
    #1;
  endtask

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one result per clock, compared away from the active edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        x = q0.pop_front();
        chk("dut0_out",  {4'h0, out0},  x.out);
        chk("dut0_idx",  {6'h0, idx0},  {5'h0, x.idx[1:0]});
        chk("dut0_tick", {7'h0, tick0}, {7'h0, x.tick});
      end
      if (q1.size() > 0) begin
        x = q1.pop_front();
        chk("dut1_out",  out1,          x.out);
        chk("dut1_idx",  {5'h0, idx1},  {5'h0, x.idx});
        chk("dut1_tick", {7'h0, tick1}, {7'h0, x.tick});
      end
    end
  end

  initial begin
    // Reset held with scan requested.
    repeat (2) drive(1, 1, 1, 0, 0, 0, 0);
    // Direct sweep.
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0, i, 7 - i);
    // Free-running scan from idx 0.
    drive(0, 1, 0, 0, 0, 0, 0);
    repeat (16) drive(0, 1, 1, 0, 0, 0, 0);
    // Load on a terminal-count clock, then the next step.
    repeat (3) drive(0, 1, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 1, 0, 2, 5);
    repeat (4) drive(0, 1, 1, 0, 0, 0, 0);
    // Disable mid-scan, resume, then reset mid-scan.
    repeat (2) drive(0, 1, 1, 0, 0, 0, 0);
    repeat (3) drive(0, 0, 1, 0, 0, 1, 1);
    repeat (6) drive(0, 1, 1, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 3, 3);
    repeat (3) drive(0, 1, 1, 0, 0, 0, 0);
    // Downward scan (only has effect when the direction port exists).
    repeat (4) drive(0, 1, 1, 0, 1, 0, 0);
    // Load ignored outside scan.
    drive(0, 1, 0, 1, 0, 1, 6);
    drive(0, 0, 0, 1, 0, 3, 2);
    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 49) == 0,
            $urandom_range(0, 9) != 0,
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) == 0,
            1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)),
            int'($urandom_range(0, 7)));
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
